psw_flag_unit: RTL and testbench

- Producer of the 2-bit processor status word (PSW_NZC) consumed by the branch-condition logic of the multicycle RISC core; the write side of that flag interface.
- Decodes the instruction in EX and captures Z/C from the ALU for flag-setting instructions.
- Holds the captured flags in a pending stage, then commits them to the architectural PSW.
- Drives a forwarded PSW so that a branch directly after a compare sees fresh flags; also supplies carry-in for ADC/SBB.

---
 rtl/psw_flag_unit.sv | 114 +++++++++++
 tb/tb_psw_flag_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psw_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : psw_flag_unit
// Description : Write side of the Z/C flag interface. Flags from flag-setting
//               EX instructions are captured into a pending stage, forwarded
//               to branch logic, then committed to the architectural PSW.
//               Optional save/restore shadow register under `PSW_SAVE_EN`.
// Revision    : 1.0 - initial release
// ============================================================================
module psw_flag_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [15:0]      ex_ins,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   input  logic             stall,
   input  logic             flush,
`ifdef PSW_SAVE_EN
   input  logic             psw_save,
   input  logic             psw_restore,
`endif
   output logic [1:0]       PSW_NZC,
   output logic [1:0]       psw_arch,
   output logic             alu_cin,
   output logic             flag_pending
);

   localparam logic [4:0] c_OP_ALU  = 5'b00000;
   localparam logic [4:0] c_OP_CMPS = 5'b00110;
   localparam logic [4:0] c_OP_ADDI = 5'b00111;
   localparam logic [4:0] c_OP_SUBI = 5'b01000;
   localparam logic [1:0] c_FN_CMP  = 2'b01;

   logic [4:0] w_opcode;
   logic [1:0] w_func;
   logic       w_set_flags;
   logic       w_zero;
   logic       w_capture;
   logic       w_restore;
   logic [1:0] w_shadow;
   logic       w_unused_ins;

   logic [1:0] r_psw_arch;
   logic       r_pend_valid;
   logic       r_pend_z;
   logic       r_pend_c;

   assign w_opcode     = ex_ins[15:11];
   assign w_func       = ex_ins[1:0];
   assign w_unused_ins = ^ex_ins[10:2];

   always_comb begin
      w_set_flags = 1'b0;
      case (w_opcode)
         c_OP_ALU, c_OP_ADDI, c_OP_SUBI: w_set_flags = 1'b1;
         c_OP_CMPS:                      w_set_flags = (w_func == c_FN_CMP);
         default:                        w_set_flags = 1'b0;
      endcase
   end

   assign w_zero    = (alu_result == '0);
   assign w_capture = ex_valid & w_set_flags & ~flush;

`ifdef PSW_SAVE_EN
   logic [1:0] r_shadow;

   // Save samples the forwarded value so an in-flight update is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= 2'b00;
      end else if (!stall && psw_save && !psw_restore) begin
         r_shadow <= PSW_NZC;
      end
   end

   assign w_restore = psw_restore;
   assign w_shadow  = r_shadow;
`else
   assign w_restore = 1'b0;
   assign w_shadow  = 2'b00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_psw_arch   <= 2'b00;
         r_pend_valid <= 1'b0;
         r_pend_z     <= 1'b0;
         r_pend_c     <= 1'b0;
      end else if (!stall) begin
         if (w_restore) begin
            r_psw_arch   <= w_shadow;
            r_pend_valid <= 1'b0;
         end else begin
            // Commit of the older entry and capture of the new one may coincide.
            if (r_pend_valid) begin
               r_psw_arch <= {r_pend_z, r_pend_c};
            end
            r_pend_valid <= w_capture;
            r_pend_z     <= w_zero;
            r_pend_c     <= alu_cout;
         end
      end
   end

   assign PSW_NZC      = r_pend_valid ? {r_pend_z, r_pend_c} : r_psw_arch;
   assign psw_arch     = r_psw_arch;
   assign alu_cin      = PSW_NZC[0];
   assign flag_pending = r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_psw_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_psw_flag_unit
// Description : Vector table, directed sequences and randomized checking of
//               psw_flag_unit against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psw_flag_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [15:0] ex_ins;
   logic [15:0] alu_result;
   logic        alu_cout;
   logic        stall;
   logic        flush;
   logic [1:0]  PSW_NZC;
   logic [1:0]  psw_arch;
   logic        alu_cin;
   logic        flag_pending;
`ifdef PSW_SAVE_EN
   logic        psw_save;
   logic        psw_restore;
`endif

   int n_pass  = 0;
   int n_total = 0;

   psw_flag_unit #(.WIDTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_valid     (ex_valid),
      .ex_ins       (ex_ins),
      .alu_result   (alu_result),
      .alu_cout     (alu_cout),
      .stall        (stall),
      .flush        (flush),
`ifdef PSW_SAVE_EN
      .psw_save     (psw_save),
      .psw_restore  (psw_restore),
`endif
      .PSW_NZC      (PSW_NZC),
      .psw_arch     (psw_arch),
      .alu_cin      (alu_cin),
      .flag_pending (flag_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ins;
      logic [15:0] res;
      logic        cout;
      logic        valid;
      logic        stl;
      logic        fl;
      logic [1:0]  nzc;
      logic [1:0]  arch;
      logic        pend;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [15:0] ins, logic [15:0] res, logic cout,
                               logic valid, logic stl, logic fl,
                               logic [1:0] nzc, logic [1:0] arch, logic pend);
      vec_t v;
      v.ins = ins; v.res = res; v.cout = cout; v.valid = valid; v.stl = stl;
      v.fl = fl; v.nzc = nzc; v.arch = arch; v.pend = pend;
      return v;
   endfunction

   task automatic chk(string nm, logic [1:0] act, logic [1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic chk_all(string tag, logic [1:0] nzc, logic [1:0] arch, logic pend);
      chk({tag, ".PSW_NZC"}, PSW_NZC, nzc);
      chk({tag, ".psw_arch"}, psw_arch, arch);
      chk({tag, ".flag_pending"}, {1'b0, flag_pending}, {1'b0, pend});
      chk({tag, ".alu_cin"}, {1'b0, alu_cin}, {1'b0, nzc[0]});
   endtask

   task automatic drive(logic [15:0] ins, logic [15:0] res, logic cout,
                        logic valid, logic stl, logic fl, logic sv, logic rs);
      ex_ins = ins; alu_result = res; alu_cout = cout;
      ex_valid = valid; stall = stl; flush = fl;
`ifdef PSW_SAVE_EN
      psw_save = sv; psw_restore = rs;
`else
      if (sv || rs) $display("save/restore requested without PSW_SAVE_EN");
`endif
   endtask

   // Reference model: architectural PSW, a queue of in-flight flag updates,
   // and the shadow copy.
   logic [1:0] m_arch;
   logic [1:0] m_shadow;
   logic [1:0] m_pq[$];

   function automatic bit sets_flags(logic [15:0] ins);
      case (ins[15:11])
         5'b00000, 5'b00111, 5'b01000: return 1'b1;
         5'b00110:                     return ins[1:0] == 2'b01;
         default:                      return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] m_fwd();
      return (m_pq.size() != 0) ? m_pq[0] : m_arch;
   endfunction

   task automatic model_step(logic [15:0] ins, logic [15:0] res, logic cout,
                             logic valid, logic stl, logic fl, logic sv, logic rs);
      logic [1:0] fwd;
      fwd = m_fwd();
      if (!stl) begin
         if (rs) begin
            m_arch = m_shadow;
            m_pq.delete();
         end else begin
            if (m_pq.size() != 0) m_arch = m_pq.pop_front();
            if (valid && !fl && sets_flags(ins)) m_pq.push_back({res == 16'd0, cout});
         end
         if (sv && !rs) m_shadow = fwd;
      end
   endtask

   localparam logic [15:0] ADD  = 16'h0000;
   localparam logic [15:0] ADC  = 16'h0001;
   localparam logic [15:0] SBB  = 16'h0003;
   localparam logic [15:0] STR  = 16'h3000;
   localparam logic [15:0] CMP  = 16'h3001;
   localparam logic [15:0] C11  = 16'h3003;
   localparam logic [15:0] ADDI = 16'h3800;
   localparam logic [15:0] SUBI = 16'h4000;
   localparam logic [15:0] JMP  = 16'h8000;
   localparam logic [15:0] BEQ  = 16'hC001;
   localparam logic [15:0] HLT  = 16'hE000;

   initial begin
      logic [4:0] ops [11];
      ops = '{5'b00000, 5'b00110, 5'b00111, 5'b01000, 5'b11000, 5'b11001,
              5'b10000, 5'b10011, 5'b11100, 5'b00001, 5'b01010};

      // Reset held two cycles while a zero-result ADD sits in EX.
      rst = 1'b1;
      drive(ADD, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      chk_all("reset", 2'b00, 2'b00, 1'b0);
      rst = 1'b0;
      drive(HLT, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk_all("post_reset", 2'b00, 2'b00, 1'b0);

      //            ins   res       cout  v     stall flush nzc    arch   pend
      tbl.push_back(mk(CMP,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1));
      tbl.push_back(mk(STR,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0));
      tbl.push_back(mk(BEQ,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0));
      tbl.push_back(mk(JMP,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0));
      tbl.push_back(mk(SUBI, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1));
      tbl.push_back(mk(HLT,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
      tbl.push_back(mk(ADD,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1));
      tbl.push_back(mk(ADC,  16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1));
      tbl.push_back(mk(HLT,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
      tbl.push_back(mk(SUBI, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1));
      tbl.push_back(mk(ADD,  16'h0005, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1));
      tbl.push_back(mk(ADD,  16'h0005, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1));
      tbl.push_back(mk(ADD,  16'h0005, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1));
      tbl.push_back(mk(HLT,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0));
      tbl.push_back(mk(CMP,  16'h0005, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 1'b1));
      tbl.push_back(mk(ADDI, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0));
      tbl.push_back(mk(HLT,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0));
      tbl.push_back(mk(ADD,  16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0));
      tbl.push_back(mk(ADD,  16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1));
      tbl.push_back(mk(SBB,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1));
      tbl.push_back(mk(HLT,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0));
      tbl.push_back(mk(C11,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0));
      tbl.push_back(mk(ADD,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0));
      tbl.push_back(mk(SUBI, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 1'b1));
      tbl.push_back(mk(ADDI, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1));
      tbl.push_back(mk(HLT,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].ins, tbl[i].res, tbl[i].cout, tbl[i].valid, tbl[i].stl,
               tbl[i].fl, 1'b0, 1'b0);
         @(posedge clk); #1;
         chk_all($sformatf("vec%0d", i), tbl[i].nzc, tbl[i].arch, tbl[i].pend);
      end

`ifdef PSW_SAVE_EN
      // Save 01, change flags to 10, restore over a pending update and a capture.
      drive(HLT,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); @(posedge clk); #1;
      chk_all("save", 2'b01, 2'b01, 1'b0);
      drive(CMP,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); @(posedge clk); #1;
      drive(HLT,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); @(posedge clk); #1;
      chk_all("set10", 2'b10, 2'b10, 1'b0);
      drive(ADD,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); @(posedge clk); #1;
      drive(ADDI, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); @(posedge clk); #1;
      chk_all("restore", 2'b01, 2'b01, 1'b0);
      drive(CMP,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); @(posedge clk); #1;
      drive(HLT,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); @(posedge clk); #1;
      chk_all("save_and_restore", 2'b01, 2'b01, 1'b0);
      drive(CMP,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); @(posedge clk); #1;
      drive(HLT,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); @(posedge clk); #1;
      chk_all("shadow_kept", 2'b01, 2'b01, 1'b0);
`endif

      // Randomized phase from a fresh reset, checked against the model.
      rst = 1'b1;
      drive(HLT, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_arch = 2'b00; m_shadow = 2'b00; m_pq.delete();
      for (int i = 0; i < 2000; i++) begin
         logic [15:0] ins, res;
         logic        cout, valid, stl, fl, sv, rs;
         ins   = {ops[$urandom_range(10, 0)], 11'($urandom)};
         res   = ($urandom_range(2, 0) == 0) ? 16'h0000 : 16'($urandom);
         cout  = 1'($urandom);
         valid = ($urandom_range(4, 0) != 0);
         stl   = ($urandom_range(3, 0) == 0);
         fl    = ($urandom_range(4, 0) == 0);
`ifdef PSW_SAVE_EN
         sv    = ($urandom_range(7, 0) == 0);
         rs    = ($urandom_range(9, 0) == 0);
`else
         sv    = 1'b0;
         rs    = 1'b0;
`endif
         drive(ins, res, cout, valid, stl, fl, sv, rs);
         model_step(ins, res, cout, valid, stl, fl, sv, rs);
         @(posedge clk); #1;
         chk_all($sformatf("rnd%0d", i), m_fwd(), m_arch, m_pq.size() != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
